// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg: shared sizing helpers and types for the key debouncer.
// Auto-repeat types are used only when MULTI_DEBOUNCER_REPEAT_EN is defined.
package multi_debouncer_pkg;

    localparam int unsigned US_CNT_W = 32;
    typedef logic [US_CNT_W-1:0] us_cnt_t;

    function automatic int unsigned glitch_cycles(
        input int unsigned mhz,
        input int unsigned ns
    );
        int unsigned c;
        c = (mhz * ns) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/debouncer_channel.sv
// debouncer_channel: one key with 2-flop sync, glitch filter and strobes.
// The auto-repeat counter exists only with MULTI_DEBOUNCER_REPEAT_EN.
module debouncer_channel
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned GLITCH_CYCLES = 1,
    parameter int unsigned CNT_W = 1,
    parameter bit KEY_ACTIVE_LOW = 1'b1
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_US = 1,
    parameter int unsigned REPEAT_PERIOD_US = 1
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    input  logic tick_i,
    output logic repeat_stb_o,
`endif
    output logic pressed_o,
    output logic press_stb_o,
    output logic release_stb_o
);

    localparam logic IDLE_PIN = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Normalise so that 1 always means pressed.
    assign sample = sync_q[1] ^ IDLE_PIN;

    always_comb begin
        cnt_d     = '0;
        stable_d  = stable_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sample != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d  = ~stable_q;
                press_d   = ~stable_q;
                release_d = stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= {2{IDLE_PIN}};
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_o     = stable_q;
    assign press_stb_o   = press_q;
    assign release_stb_o = release_q;

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam int unsigned DLY = (REPEAT_DELAY_US == 0) ? 1 : REPEAT_DELAY_US;
    localparam int unsigned PER = (REPEAT_PERIOD_US == 0) ? 1 : REPEAT_PERIOD_US;
    localparam us_cnt_t DLY_LAST = us_cnt_t'(DLY - 1);
    localparam us_cnt_t PER_LAST = us_cnt_t'(PER - 1);

    us_cnt_t rep_cnt_q, rep_cnt_d;
    logic    armed_q, armed_d;
    logic    repeat_q, repeat_d;

    // Counting only runs while held; a release edge cancels any pending pulse.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        armed_d   = armed_q;
        repeat_d  = 1'b0;
        if (!stable_q || (stable_d != stable_q)) begin
            rep_cnt_d = '0;
            armed_d   = 1'b0;
        end else if (tick_i) begin
            if (rep_cnt_q == (armed_q ? PER_LAST : DLY_LAST)) begin
                repeat_d  = 1'b1;
                rep_cnt_d = '0;
                armed_d   = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + us_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_cnt_q <= '0;
            armed_q   <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            armed_q   <= armed_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_stb_o = repeat_q;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N independent debounced keys with press/release strobes.
// Define MULTI_DEBOUNCER_REPEAT_EN to build the 1 us prescaler and auto-repeat.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned GLITCH_TIME_NS = 20_000,
    parameter int unsigned KEY_ACTIVE_LOW = 1
`ifdef MULTI_DEBOUNCER_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_US = 500_000,
    parameter int unsigned REPEAT_PERIOD_US = 100_000
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] key_i,
    output logic [CHANNELS-1:0] pressed_o,
    output logic [CHANNELS-1:0] press_stb_o,
    output logic [CHANNELS-1:0] release_stb_o,
    output logic [CHANNELS-1:0] repeat_stb_o
);

    localparam int unsigned GLITCH_CYCLES =
        glitch_cycles(CLK_FREQ_MHZ, GLITCH_TIME_NS);
    localparam int unsigned CNT_W = cnt_width(GLITCH_CYCLES);
    localparam bit ACT_LOW = (KEY_ACTIVE_LOW != 0);

`ifdef MULTI_DEBOUNCER_REPEAT_EN
    localparam int unsigned MHZ = (CLK_FREQ_MHZ == 0) ? 1 : CLK_FREQ_MHZ;
    localparam us_cnt_t PRE_LAST = us_cnt_t'(MHZ - 1);

    us_cnt_t pre_q, pre_d;
    logic    tick;

    // One shared 1 us tick for every channel's repeat counter.
    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + us_cnt_t'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign repeat_stb_o = '0;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debouncer_channel #(
            .GLITCH_CYCLES   (GLITCH_CYCLES),
            .CNT_W           (CNT_W),
            .KEY_ACTIVE_LOW  (ACT_LOW)
`ifdef MULTI_DEBOUNCER_REPEAT_EN
            ,
            .REPEAT_DELAY_US (REPEAT_DELAY_US),
            .REPEAT_PERIOD_US(REPEAT_PERIOD_US)
`endif
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .key_i        (key_i[g]),
`ifdef MULTI_DEBOUNCER_REPEAT_EN
            .tick_i       (tick),
            .repeat_stb_o (repeat_stb_o[g]),
`endif
            .pressed_o    (pressed_o[g]),
            .press_stb_o  (press_stb_o[g]),
            .release_stb_o(release_stb_o[g])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: segment table plus per-cycle scoreboard against a
// sample-window model; repeat checks run with MULTI_DEBOUNCER_REPEAT_EN.
module tb_multi_debouncer;

    localparam int G  = 5;
    localparam int HW = G + 2;

    typedef struct packed {
        logic [3:0] pressed;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        int         cycles;
        logic [3:0] pressed;
        logic [3:0] press_or;
        int         press_n;
        logic [3:0] rel_or;
        int         rel_n;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic [3:0] pressed_o, press_stb_o, release_stb_o, repeat_stb_o;

    int checks = 0;
    int errors = 0;

    exp_t          sb[$];
    logic [HW-1:0] hist [4];
    logic [3:0]    m_stable;
    int            hold [4];

    logic [3:0] obs_pressed, obs_press, obs_rel, obs_rep;
    logic [3:0] acc_press, acc_rel;
    int         n_press, n_rel;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS        (4),
        .CLK_FREQ_MHZ    (1),
        .GLITCH_TIME_NS  (5000),
        .KEY_ACTIVE_LOW  (1)
`ifdef MULTI_DEBOUNCER_REPEAT_EN
        ,
        .REPEAT_DELAY_US (10),
        .REPEAT_PERIOD_US(4)
`endif
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .key_i        (key),
        .pressed_o    (pressed_o),
        .press_stb_o  (press_stb_o),
        .release_stb_o(release_stb_o),
        .repeat_stb_o (repeat_stb_o)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < 4; c++) begin
            hist[c] = '0;
            hold[c] = 0;
        end
        m_stable = '0;
    endtask

    // A level change is taken once the last G synchronised samples
    // (pins captured 2..G+1 edges ago) all differ from the stable level.
    task automatic model_edge(input logic [3:0] k, output exp_t e);
        e = '0;
        for (int c = 0; c < 4; c++) begin
            logic lvl;
            lvl = m_stable[c];
            hist[c] = {hist[c][HW-2:0], ~k[c]};
            if (hist[c][HW-1:2] == {G{~lvl}}) begin
                m_stable[c] = ~lvl;
                e.press[c]  = ~lvl;
                e.rel[c]    = lvl;
                hold[c]     = 0;
            end else if (lvl) begin
                hold[c]++;
`ifdef MULTI_DEBOUNCER_REPEAT_EN
                if (hold[c] >= 10 && ((hold[c] - 10) % 4) == 0)
                    e.rep[c] = 1'b1;
`endif
            end
            e.pressed[c] = m_stable[c];
        end
    endtask

    task automatic step(input logic [3:0] k);
        exp_t e;
        key = k;
        @(posedge clk);
        model_edge(k, e);
        sb.push_back(e);
        #3;
        obs_pressed = pressed_o;
        obs_press   = press_stb_o;
        obs_rel     = release_stb_o;
        obs_rep     = repeat_stb_o;
        acc_press   = acc_press | press_stb_o;
        acc_rel     = acc_rel | release_stb_o;
        if (press_stb_o != 0) n_press++;
        if (release_stb_o != 0) n_rel++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("cycle", {pressed_o, press_stb_o, release_stb_o, repeat_stb_o}, e);
        end
    end

    initial begin
        vec_t tbl[11];
        int   lat;
        int   rel_off;
        int   rep_off[$];

        tbl[0]  = '{4'b1111, 20, 4'b0000, 4'b0000, 0, 4'b0000, 0};
        tbl[1]  = '{4'b1110, 10, 4'b0001, 4'b0001, 1, 4'b0000, 0};
        tbl[2]  = '{4'b1100,  4, 4'b0001, 4'b0000, 0, 4'b0000, 0};
        tbl[3]  = '{4'b1110,  1, 4'b0001, 4'b0000, 0, 4'b0000, 0};
        tbl[4]  = '{4'b1100,  4, 4'b0001, 4'b0000, 0, 4'b0000, 0};
        tbl[5]  = '{4'b1110, 10, 4'b0001, 4'b0000, 0, 4'b0000, 0};
        tbl[6]  = '{4'b0010, 10, 4'b1101, 4'b1100, 1, 4'b0000, 0};
        tbl[7]  = '{4'b1110, 10, 4'b0001, 4'b0000, 0, 4'b1100, 1};
        tbl[8]  = '{4'b1111, 10, 4'b0000, 4'b0000, 0, 4'b0001, 1};
        tbl[9]  = '{4'b1110,  5, 4'b0000, 4'b0000, 0, 4'b0000, 0};
        tbl[10] = '{4'b1111, 10, 4'b0000, 4'b0001, 1, 4'b0001, 1};

        reset_model();
        rst_n = 1'b0;
        key   = 4'hF;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs",
                 {pressed_o, press_stb_o, release_stb_o, repeat_stb_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            acc_press = '0;
            acc_rel   = '0;
            n_press   = 0;
            n_rel     = 0;
            for (int j = 0; j < tbl[i].cycles; j++) step(tbl[i].key);
            check($sformatf("seg%0d_pressed", i), obs_pressed, tbl[i].pressed);
            check($sformatf("seg%0d_press_or", i), acc_press, tbl[i].press_or);
            check($sformatf("seg%0d_press_n", i), n_press, tbl[i].press_n);
            check($sformatf("seg%0d_rel_or", i), acc_rel, tbl[i].rel_or);
            check($sformatf("seg%0d_rel_n", i), n_rel, tbl[i].rel_n);
        end

        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(4'b1110);
            if (obs_press[0]) lat = i;
        end
        check("press_latency", lat, 7);
        step(4'b1110);
        check("press_one_cycle", obs_press[0], 1'b0);
        check("pressed_held", obs_pressed[0], 1'b1);

        repeat (12) step(4'b1111);
        repeat (12) step(4'b0111);
        check("key3_pressed", obs_pressed, 4'b1000);
        repeat (5) step(4'b0110);
        #1 rst_n = 1'b0;
        #1 check("reset_async",
                 {pressed_o, press_stb_o, release_stb_o, repeat_stb_o}, 0);
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(4'b0110);
            if (obs_press[0]) lat = i;
        end
        check("post_reset_latency", lat, 7);
        check("post_reset_press", obs_press, 4'b1001);

`ifdef MULTI_DEBOUNCER_REPEAT_EN
        repeat (12) step(4'b1111);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step(4'b1110);
            if (obs_press[0]) lat = i;
        end
        check("rep_press_latency", lat, 7);
        rel_off = 0;
        for (int o = 1; o <= 40; o++) begin
            step((o >= 24) ? 4'b1111 : 4'b1110);
            if (obs_rep[0]) rep_off.push_back(o);
            if (obs_rel[0]) rel_off = o;
        end
        check("rep_count", rep_off.size(), 5);
        for (int i = 0; i < 5 && i < rep_off.size(); i++)
            check($sformatf("rep_off%0d", i), rep_off[i], 10 + 4 * i);
        check("rep_release_off", rel_off, 30);
`endif

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
